// File: rtl/lane_traffic_ctrl.sv
// Shared step engine for one road lane: N_CARS cars advance together on a level-scaled tick.
// Define LANE_TRAFFIC_REVERSE_EN to add i_Reverse, which flips the lane direction at the next step.
module lane_traffic_ctrl #(
    parameter int unsigned N_CARS      = 3,
    parameter int unsigned LANE_Y      = 128,
    parameter int unsigned START_X     = 0,
    parameter int unsigned SPACING     = 200,
    parameter bit          DIRECTION   = 1'b1,
    parameter int unsigned GAME_W      = 640,
    parameter int unsigned BASE_PERIOD = 50000,
    parameter int unsigned PERIOD_STEP = 5000,
    parameter int unsigned MIN_PERIOD  = 10000
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic [3:0]            i_Level,
    input  logic [1:0]            i_Game_State,
`ifdef LANE_TRAFFIC_REVERSE_EN
    input  logic                  i_Reverse,
`endif
    output logic [10*N_CARS-1:0]  o_CarX,
    output logic [8:0]            o_CarY,
    output logic                  o_Step,
    output logic                  o_Moving
);

    localparam int unsigned X_W    = 10;
    localparam int unsigned BUS_W  = X_W * N_CARS;
    localparam int unsigned BASE_W = $clog2(BASE_PERIOD);
    localparam int unsigned MIN_W  = $clog2(MIN_PERIOD);
    localparam int unsigned CNT_W0 = (BASE_W > 17) ? BASE_W : 17;
    localparam int unsigned CNT_W  = (MIN_W > CNT_W0) ? MIN_W : CNT_W0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSE  = 2'b10,
        ST_RELOAD = 2'b11
    } mode_e;

    // Evenly spaced start positions, folded into the playfield so any spacing is legal.
    function automatic logic [BUS_W-1:0] reset_layout();
        logic [BUS_W-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < N_CARS; k++) begin
            v[X_W*k +: X_W] = X_W'((START_X + k * SPACING) % GAME_W);
        end
        return v;
    endfunction

    localparam logic [BUS_W-1:0] LAYOUT = reset_layout();

    mode_e              mode_c;
    logic [3:0]         lvl_c;
    logic signed [19:0] p_raw_c;
    logic [19:0]        period_c;
    logic               step_due_c;
    logic               step_fire_c;
    logic [CNT_W-1:0]   cnt_q;
    logic [BUS_W-1:0]   pos_q;
    logic [BUS_W-1:0]   pos_step_c;
    logic               step_q;

    assign mode_c = mode_e'(i_Game_State);

    // Step period: linear in level, clamped at the floor.
    always_comb begin
        lvl_c    = (i_Level == 4'd0) ? 4'd1 : i_Level;
        p_raw_c  = $signed(20'(BASE_PERIOD))
                 - $signed(20'(lvl_c - 4'd1)) * $signed(20'(PERIOD_STEP));
        period_c = (p_raw_c < $signed(20'(MIN_PERIOD))) ? 20'(MIN_PERIOD) : p_raw_c;
    end

    // cnt + 1 >= P is cnt >= P - 1 without the subtraction.
    assign step_due_c  = (32'(cnt_q) + 32'd1) >= 32'(period_c);
    assign step_fire_c = (mode_c == ST_RUN) && step_due_c;

`ifdef LANE_TRAFFIC_REVERSE_EN
    logic rev_q;
    logic pend_q;
    logic dir_q;
    logic rise_c;
    logic dir_c;

    assign rise_c = i_Reverse & ~rev_q;
    assign dir_c  = pend_q ? ~dir_q : dir_q;

    // A pending reversal is consumed by the step it applies to.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            rev_q  <= 1'b0;
            pend_q <= 1'b0;
            dir_q  <= DIRECTION;
        end else begin
            rev_q <= i_Reverse;
            if (mode_c == ST_RELOAD) begin
                pend_q <= 1'b0;
                dir_q  <= DIRECTION;
            end else if (step_fire_c) begin
                pend_q <= rise_c;
                dir_q  <= dir_c;
            end else if (rise_c) begin
                pend_q <= 1'b1;
            end
        end
    end
`else
    logic dir_c;
    assign dir_c = DIRECTION;
`endif

    // One-pixel move with wrap at both screen edges.
    always_comb begin
        pos_step_c = pos_q;
        for (int unsigned k = 0; k < N_CARS; k++) begin
            if (dir_c) begin
                pos_step_c[X_W*k +: X_W] = (pos_q[X_W*k +: X_W] == X_W'(GAME_W - 1))
                                         ? '0 : pos_q[X_W*k +: X_W] + X_W'(1);
            end else begin
                pos_step_c[X_W*k +: X_W] = (pos_q[X_W*k +: X_W] == '0)
                                         ? X_W'(GAME_W - 1) : pos_q[X_W*k +: X_W] - X_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pos_q  <= LAYOUT;
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (mode_c)
                ST_RUN: begin
                    if (step_due_c) begin
                        cnt_q  <= '0;
                        pos_q  <= pos_step_c;
                        step_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELOAD: begin
                    pos_q <= LAYOUT;
                    cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output stage: o_Step lines up with the o_CarX it announces.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_CarX   <= LAYOUT;
            o_CarY   <= 9'(LANE_Y);
            o_Step   <= 1'b0;
            o_Moving <= 1'b0;
        end else begin
            o_CarX   <= pos_q;
            o_CarY   <= 9'(LANE_Y);
            o_Step   <= step_q;
            o_Moving <= (mode_c == ST_RUN);
        end
    end

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Bench for lane_traffic_ctrl: two lanes (right-moving and left-moving) against a position/period model.
module tb_lane_traffic_ctrl;

    localparam int unsigned W = 640;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  level;
    logic [1:0]  gs;
    logic        rev;
    logic [29:0] a_x;
    logic [8:0]  a_y;
    logic        a_step, a_mov;
    logic [39:0] b_x;
    logic [8:0]  b_y;
    logic        b_step, b_mov;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lane_traffic_ctrl #(
        .N_CARS(3), .LANE_Y(128), .START_X(0), .SPACING(200), .DIRECTION(1'b1),
        .GAME_W(W), .BASE_PERIOD(8), .PERIOD_STEP(1), .MIN_PERIOD(3)
    ) dut_a (
        .i_Clk(clk), .i_Reset(rst), .i_Level(level), .i_Game_State(gs),
`ifdef LANE_TRAFFIC_REVERSE_EN
        .i_Reverse(rev),
`endif
        .o_CarX(a_x), .o_CarY(a_y), .o_Step(a_step), .o_Moving(a_mov)
    );

    lane_traffic_ctrl #(
        .N_CARS(4), .LANE_Y(77), .START_X(0), .SPACING(300), .DIRECTION(1'b0),
        .GAME_W(W), .BASE_PERIOD(5), .PERIOD_STEP(1), .MIN_PERIOD(2)
    ) dut_b (
        .i_Clk(clk), .i_Reset(rst), .i_Level(level), .i_Game_State(gs),
`ifdef LANE_TRAFFIC_REVERSE_EN
        .i_Reverse(rev),
`endif
        .o_CarX(b_x), .o_CarY(b_y), .o_Step(b_step), .o_Moving(b_mov)
    );

    // Model configuration per lane (index 0 = dut_a, 1 = dut_b)
    int p_n[2]     = '{3, 4};
    int p_y[2]     = '{128, 77};
    int p_start[2] = '{0, 0};
    int p_sp[2]    = '{200, 300};
    int p_dir[2]   = '{1, 0};
    int p_base[2]  = '{8, 5};
    int p_stp[2]   = '{1, 1};
    int p_min[2]   = '{3, 2};

    // Model state: architectural positions, tick count, and the one-cycle-late visible outputs
    int pos[2][8];
    int vis_x[2][8];
    int cnt[2];
    int stepped[2];
    int vis_step[2];
    int vis_mov[2];
    int dir[2];
    int pend[2];
    int rev_prev;

    function automatic int layout_x(int d, int k);
        return (p_start[d] + k * p_sp[d]) % W;
    endfunction

    function automatic int period_of(int d, int l);
        int lv, p;
        lv = (l == 0) ? 1 : l;
        p  = p_base[d] - (lv - 1) * p_stp[d];
        return (p < p_min[d]) ? p_min[d] : p;
    endfunction

    function automatic logic [63:0] exp_x(int d);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < p_n[d]; k++) v[10*k +: 10] = 10'(vis_x[d][k]);
        return v;
    endfunction

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_edge();
        int rise;
        rise = (rev && !rev_prev) ? 1 : 0;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < p_n[d]; k++) begin
                    pos[d][k]   = layout_x(d, k);
                    vis_x[d][k] = layout_x(d, k);
                end
                cnt[d] = 0; stepped[d] = 0; vis_step[d] = 0; vis_mov[d] = 0;
                dir[d] = p_dir[d]; pend[d] = 0;
            end else begin
                for (int k = 0; k < p_n[d]; k++) vis_x[d][k] = pos[d][k];
                vis_step[d] = stepped[d];
                vis_mov[d]  = (gs == 2'b01) ? 1 : 0;
                stepped[d]  = 0;
                if (gs == 2'b11) begin
                    for (int k = 0; k < p_n[d]; k++) pos[d][k] = layout_x(d, k);
                    cnt[d] = 0; dir[d] = p_dir[d]; pend[d] = 0;
                end else if (gs == 2'b01 && cnt[d] + 1 >= period_of(d, int'(level))) begin
                    cnt[d] = 0;
                    stepped[d] = 1;
`ifdef LANE_TRAFFIC_REVERSE_EN
                    if (pend[d] != 0) dir[d] = 1 - dir[d];
                    pend[d] = rise;
`endif
                    for (int k = 0; k < p_n[d]; k++)
                        pos[d][k] = (pos[d][k] + ((dir[d] != 0) ? 1 : -1) + W) % W;
                end else begin
                    if (gs == 2'b01) cnt[d] = cnt[d] + 1;
`ifdef LANE_TRAFFIC_REVERSE_EN
                    if (rise != 0) pend[d] = 1;
`endif
                end
            end
        end
        rev_prev = rst ? 0 : int'(rev);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("a_carx", 64'(a_x), exp_x(0));
        chk("a_step", 64'(a_step), 64'(vis_step[0]));
        chk("a_moving", 64'(a_mov), 64'(vis_mov[0]));
        chk("a_cary", 64'(a_y), 64'(p_y[0]));
        chk("b_carx", 64'(b_x), exp_x(1));
        chk("b_step", 64'(b_step), 64'(vis_step[1]));
        chk("b_moving", 64'(b_mov), 64'(vis_mov[1]));
        chk("b_cary", 64'(b_y), 64'(p_y[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_step(input int d, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (((d == 0) ? a_step : b_step) !== 1'b1 && n < 100);
        if (n >= 100) chk("step_timeout", 64'(n), 64'(0));
    endtask

    int          per_tab[16] = '{8, 8, 7, 6, 5, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    logic [29:0] a_layout    = {10'd400, 10'd200, 10'd0};
    logic [39:0] b_layout    = {10'd260, 10'd600, 10'd300, 10'd0};
    logic [39:0] b_first     = {10'd259, 10'd599, 10'd299, 10'd639};
    logic [29:0] saved;
    int          n, steps;

    initial begin
        rst = 1'b1; level = 4'd1; gs = 2'b00; rev = 1'b0; rev_prev = 0;
        cycle();
        cycle();
        chk("reset_a_layout", 64'(a_x), 64'(a_layout));
        chk("reset_b_layout", 64'(b_x), 64'(b_layout));
        chk("reset_a_y", 64'(a_y), 64'd128);
        chk("reset_step", 64'(a_step), 64'd0);
        chk("reset_moving", 64'(a_mov), 64'd0);

        // Left-moving lane: car at 0 wraps to 639 on the same step as the others move
        rst = 1'b0; gs = 2'b01;
        wait_step(1, n);
        chk("b_first_step_wrap", 64'(b_x), 64'(b_first));

        // Right-moving lane: 640 steps bring every car back to its start
        rst = 1'b1; cycle(); rst = 1'b0;
        steps = 0;
        while (steps < 640) begin
            wait_step(0, n);
            steps++;
        end
        chk("a_full_lap", 64'(a_x), 64'(a_layout));

        // Step period per level, including level 0 and the floor
        for (int l = 0; l < 16; l++) begin
            level = 4'(l);
            wait_step(0, n);
            wait_step(0, n);
            chk($sformatf("period_l%0d", l), 64'(n), 64'(per_tab[l]));
        end

        // Level raised mid-count past the new period: step on the very next edge
        level = 4'd1;
        wait_step(0, n);
        wait_step(0, n);
        repeat (5) cycle();
        level = 4'd6;
        cycle();
        chk("midcount_not_yet", 64'(a_step), 64'd0);
        cycle();
        chk("midcount_step", 64'(a_step), 64'd1);

        // Pause holds everything, resume continues the count
        gs = 2'b10;
        saved = a_x;
        repeat (100) cycle();
        chk("pause_hold_x", 64'(a_x), 64'(saved));
        chk("pause_moving", 64'(a_mov), 64'd0);
        gs = 2'b01;
        repeat (20) cycle();

        // Reload after many steps restores layout without a step pulse
        level = 4'd7;
        repeat (150) cycle();
        gs = 2'b11;
        cycle();
        cycle();
        chk("reload_layout", 64'(a_x), 64'(a_layout));
        chk("reload_no_step", 64'(a_step), 64'd0);
        gs = 2'b01;

`ifdef LANE_TRAFFIC_REVERSE_EN
        wait_step(0, n);
        saved = a_x;
        rev = 1'b1; cycle(); rev = 1'b0;
        wait_step(0, n);
        chk("reverse_decrements", 64'(a_x[9:0]), 64'((int'(saved[9:0]) + W - 1) % W));
        gs = 2'b11; cycle(); gs = 2'b01;
        wait_step(0, n);
        chk("reload_restores_dir", 64'(a_x[9:0]), 64'd1);
`endif

        // Randomized traffic: state, level, reverse and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 7))
                    0:       gs = 2'b00;
                    5:       gs = 2'b10;
                    6:       gs = 2'b11;
                    default: gs = 2'b01;
                endcase
            end
            if ($urandom_range(0, 19) == 0) level = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) rev = ~rev;
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lane_traffic_ctrl.md
Name: lane_traffic_ctrl

Overview:
- Drives one road lane holding N_CARS cars that move together, replacing per-car controllers with a single shared tick engine.
- Step period comes from i_Level through a parametrised linear law with a floor value.
- Cars start evenly spaced and wrap independently at the screen edges.
- Sits between the game FSM (which supplies i_Level and i_Game_State) and the collision/render logic (which consumes the packed X bus and the lane Y).

Parameters:
N_CARS, 3, cars in the lane (1..8)
LANE_Y, 128, fixed Y of the lane, 9 bits
START_X, 0, X of car 0 at reset
SPACING, 200, X distance between consecutive cars at reset
DIRECTION, 1, 1 = move right (+X), 0 = move left (-X)
GAME_W, 640, playfield width in pixels; valid X is 0..GAME_W-1
BASE_PERIOD, 50000, clocks per step at level 1
PERIOD_STEP, 5000, period decrement per level above 1
MIN_PERIOD, 10000, period floor

Ports:
i_Clk  in  1  clock
i_Reset  in  1  synchronous, active-high reset
i_Level  in  4  game level; 0 is treated as 1
i_Game_State  in  2  00 idle, 01 running, 10 paused/game-over, 11 reload
o_CarX  out  10*N_CARS  packed X positions; car k occupies bits [10k+9:10k]
o_CarY  out  9  lane Y, constant LANE_Y
o_Step  out  1  one-cycle pulse, high in the cycle o_CarX shows a new step
o_Moving  out  1  high while i_Game_State==01 and not in reset

Behaviour:
- Period, combinational from i_Level:
  - L = max(i_Level,1)
  - P = BASE_PERIOD - (L-1)*PERIOD_STEP, computed in 20 bits signed
  - if P < MIN_PERIOD then P = MIN_PERIOD
- Counter: 17 bits minimum, sized by $clog2(BASE_PERIOD).
- State machine, encoded directly from i_Game_State each cycle:
  - IDLE (00): positions and counter hold.
  - RUN (01): counter increments. When counter >= P-1, the counter clears and a step occurs in the same edge.
  - PAUSE (10): positions and counter hold. Return to RUN resumes the count, no restart.
  - RELOAD (11): positions return to reset layout and the counter clears. o_Step stays low.
- The ">=" compare is required: if i_Level rises mid-count so that the counter already exceeds the new P-1, the step fires on the next RUN edge.
- Step, applied to all cars simultaneously:
  - DIRECTION=1: x' = (x==GAME_W-1) ? 0 : x+1
  - DIRECTION=0: x' = (x==0) ? GAME_W-1 : x-1
- Reset layout:
  - car k X = (START_X + k*SPACING) mod GAME_W, computed at elaboration.
  - The mod is required so any N_CARS*SPACING is legal.
- Outputs are registered, one cycle after the internal position update:
  - o_CarX mirrors the internal positions.
  - o_Step is registered with the same alignment, so o_Step and the new o_CarX appear together.
- Reset values:
  - internal positions = reset layout; o_CarX = reset layout on the first edge with i_Reset high.
  - o_CarY = LANE_Y; o_Step = 0; o_Moving = 0; counter = 0.
- Priority: i_Reset > RELOAD > RUN/PAUSE/IDLE.
- Reset asserted in the same cycle a step would fire: reset wins, no step.
- o_Moving: registered; equals (i_Game_State==01) delayed one cycle; 0 during reset.

Optional Feature:
- Macro: LANE_TRAFFIC_REVERSE_EN.
- When defined:
  - adds input i_Reverse (1 bit) and an internal direction register initialised to DIRECTION.
  - a rising edge of i_Reverse sets a pending flag.
  - the direction toggles at the next step, and that step already uses the new direction.
  - the pending flag clears at that step.
  - reset and RELOAD restore the direction to DIRECTION and clear the pending flag.
- When not defined:
  - no i_Reverse port; direction is the constant DIRECTION; no extra registers.

Test Plan:
- Reset, N_CARS=3, START_X=0, SPACING=200 -> o_CarX = {400,200,0}, o_CarY=128, o_Step=0, o_Moving=0.
- Level 1, RUN, BASE_PERIOD=4 (bench override) -> o_Step pulses every 4 clocks; car 0 X goes 0,1,2...; after a full GAME_W steps the X returns to its start value.
- Wrap, DIRECTION=1 -> car at 639 steps to 0; DIRECTION=0 -> car at 0 steps to 639 on the same step that moves the others.
- Level sweep 1..15, defaults -> P = 50000, 45000, ..., 10000 at level 9, then 10000 for levels 10..15. Level 0 gives 50000.
- Mid-count change: counter at 30000 at level 1, i_Level switches to 8 (P=15000) -> step on the next clock, counter then restarts from 0. Next, pause 100 clocks -> no change; resume -> next step arrives after the remaining count.
- RELOAD after 50 steps -> reset layout restored and no o_Step pulse. With LANE_TRAFFIC_REVERSE_EN: pulse i_Reverse between steps -> the next step decrements X; RELOAD restores +X.
